// File: rtl/reg_scan4_pkg.sv
// Shared constants for the four-entry register bank and its scan sequencer.
package reg_scan4_pkg;

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned IDX_W       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/reg_scan4_next_unmasked4.sv
// Finds the next set mask bit strictly above cur, or the lowest set bit when first is asserted.
module next_unmasked4
  import reg_scan4_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] mask,
  input  logic [IDX_W-1:0]       cur,
  input  logic                   first,
  output logic [IDX_W-1:0]       nextIdx,
  output logic                   found
);

  always_comb begin
    nextIdx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!found && mask[i] && (first || (i > int'(cur)))) begin
        found   = 1'b1;
        nextIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reg_scan4.sv
// Four-entry register bank plus round-robin scan sequencer driving a downstream 4:1 mux select.
module reg_scan4
  import reg_scan4_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = 8,
  parameter int unsigned BUS_WIDTH       = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       WriteEnable,
  input  logic [BUS_WIDTH-1:0]       WriteAddr,
  input  logic [INPUT_BIT_WIDTH-1:0] WriteData,
  input  logic                       Start,
  input  logic [NUM_ENTRIES-1:0]     Mask,
  input  logic                       Ready,
  output logic [INPUT_BIT_WIDTH-1:0] OutputA,
  output logic [INPUT_BIT_WIDTH-1:0] OutputB,
  output logic [INPUT_BIT_WIDTH-1:0] OutputC,
  output logic [INPUT_BIT_WIDTH-1:0] OutputD,
  output logic [BUS_WIDTH-1:0]       Select,
  output logic                       Valid,
  output logic                       Busy,
  output logic                       Done,
  output logic                       WriteError
);

  state_t                 state;
  logic [NUM_ENTRIES-1:0] maskReg;
  logic [NUM_ENTRIES-1:0] searchMask;
  logic                   searchFirst;
  logic [IDX_W-1:0]       nextIdx;
  logic                   nextFound;

  // One search unit serves both scan start (live Mask) and stepping (latched mask).
  assign searchFirst = (state == IDLE);
  assign searchMask  = searchFirst ? Mask : maskReg;

  next_unmasked4 u_next (
    .mask    (searchMask),
    .cur     (IDX_W'(Select)),
    .first   (searchFirst),
    .nextIdx (nextIdx),
    .found   (nextFound)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      maskReg    <= '0;
      OutputA    <= '0;
      OutputB    <= '0;
      OutputC    <= '0;
      OutputD    <= '0;
      Select     <= '0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      WriteError <= 1'b0;
    end else begin
      Done       <= 1'b0;
      WriteError <= 1'b0;

      // Bank is frozen while a scan is draining it.
      if (WriteEnable) begin
        if (state == SCAN) begin
          WriteError <= 1'b1;
        end else begin
          case (WriteAddr)
            BUS_WIDTH'(0): OutputA <= WriteData;
            BUS_WIDTH'(1): OutputB <= WriteData;
            BUS_WIDTH'(2): OutputC <= WriteData;
            default:       OutputD <= WriteData;
          endcase
        end
      end

      case (state)
        IDLE: begin
          if (Start) begin
            if (nextFound) begin
              maskReg <= Mask;
              Select  <= BUS_WIDTH'(nextIdx);
              Valid   <= 1'b1;
              Busy    <= 1'b1;
              state   <= SCAN;
            end else begin
              Done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (Valid && Ready) begin
            if (nextFound) begin
              Select <= BUS_WIDTH'(nextIdx);
            end else begin
              Valid <= 1'b0;
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_scan4.md
# reg_scan4

Four-entry register bank with a round-robin scan sequencer, placed directly upstream of the 4:1 register multiplexer. It holds the four operands the multiplexer chooses between and generates that multiplexer's select bus. On request it walks the selected entries in index order, one entry per Valid/Ready handshake, so a downstream consumer can drain the bank through the mux.

## Interface
Parameters:
- INPUT_BIT_WIDTH, 8, width of each register entry and of the write data.
- BUS_WIDTH, 2, select/address width. Fixed at 2: four entries.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- WriteEnable  input  1  write strobe for the bank.
- WriteAddr  input  BUS_WIDTH  entry to write (0=A … 3=D).
- WriteData  input  INPUT_BIT_WIDTH  data to write.
- Start  input  1  begin a scan. Sampled only in IDLE.
- Mask  input  4  entries to visit (bit i = entry i). Sampled with Start.
- Ready  input  1  downstream accepts the current entry.
- OutputA..OutputD  output  INPUT_BIT_WIDTH each  register contents, wired to the mux data inputs.
- Select  output  BUS_WIDTH  registered index of the current entry, wired to the mux select.
- Valid  output  1  Select names an entry awaiting acceptance.
- Busy  output  1  scan in progress.
- Done  output  1  one-cycle pulse at scan completion.
- WriteError  output  1  one-cycle pulse when a write is rejected.

## Operation
- States: IDLE, SCAN. All outputs are registered.
- Reset (asynchronous) clears OutputA–D, Select, Valid, Busy, Done and WriteError to 0 and sets the state to IDLE. Reset mid-scan abandons the scan and produces no Done.
- Writes in IDLE:
  - WriteEnable=1 loads WriteData into entry WriteAddr at the edge.
  - Writes are accepted in every cycle.
- Writes while Busy=1:
  - The write is ignored and the bank is unchanged.
  - WriteError=1 for the following cycle.
- IDLE with Start=1 and Mask≠0:
  - The latched mask is stored.
  - Next state is SCAN, with Select = lowest set Mask bit, Valid=1, Busy=1.
- IDLE with Start=1 and Mask=0:
  - The state stays IDLE and Valid is never raised.
  - Done=1 for the next cycle.
- SCAN, edge with Valid&Ready:
  - The current entry is accepted.
  - If the latched mask has a set bit above Select, Select moves to that index and Valid stays 1.
  - Otherwise the next state is IDLE with Valid=0, Busy=0 and Done=1 for one cycle.
- SCAN with Ready=0: Select and Valid hold.
- Start in SCAN is ignored. Mask is ignored except at scan start.
- A Start and a write in the same IDLE cycle both take effect: the write lands and the scan begins.

## Timing
- Start to first Valid: 1 cycle. Start is sampled at edge t; Valid=1 and Select are set after edge t.
- Throughput: one entry per cycle when Ready is held at 1.
- A full 4-entry scan with Ready=1 gives Valid for 4 cycles, followed by Done in the cycle after the last acceptance.
- The mux is combinational, so its output for entry Select is valid in the same cycle as Valid.
- A write becomes visible on OutputX one cycle after the edge where WriteEnable is sampled.
- Done and WriteError are exactly one cycle wide.
- Back-to-back scans: a Start may be sampled in the same cycle Done is high. The new scan's Valid appears 1 cycle later.

## Structure
- Shared constants header, alongside the common test utilities:
  - state encodings (IDLE=0, SCAN=1);
  - entry count 4.
- One sub-module, next_unmasked4 (combinational):
  - inputs: mask[3:0], current index, "first" flag;
  - outputs: next index and a found flag;
  - it returns the lowest set bit strictly above the current index, or the lowest set bit overall when "first" is set.
- The top-level test instantiates reg_scan4 feeding the existing 4:1 register mux, so both blocks are verified together.

## Test plan
- Reset check: assert Reset mid-run. Outputs are all 0, the state is IDLE, and Done is not pulsed.
- Load and full scan:
  - Write A=42, B=15, C=2, D=0, then Start with Mask=4'b1111 and Ready=1.
  - Select steps 0,1,2,3 over 4 cycles and the mux output reads 42, 15, 2, 0.
  - Done pulses once.
- Sparse mask with back-pressure:
  - Mask=4'b1010 with Ready low for 3 cycles.
  - Select holds at 1 with Valid=1, then moves to 3, then Done.
- Empty mask: Start with Mask=0 gives Done one cycle later and Valid stays 0 throughout.
- Write during scan:
  - Write C=99 while Busy.
  - WriteError pulses once, OutputC stays 2 and the scan continues unaffected.
- Back-to-back scans: Start asserted in the Done cycle starts the second scan with Valid 1 cycle later.
